// File: rtl/scan_sched.sv
// Raster scheduler for the metaball datapath: strobes each pixel, waits for all evaluators,
// thresholds the field sum and writes one bit per pixel. Optional watchdog: SCAN_SCHED_WDOG_EN.
module scan_sched #(
    parameter int unsigned H_RES   = 32,
    parameter int unsigned V_RES   = 32,
    parameter logic [31:0] STEP    = 32'h0000_8000,
    parameter int unsigned N_BALLS = 2,
    parameter logic [31:0] THRESH  = 32'h0001_0000,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [N_BALLS-1:0] mb_vld,
    input  logic [31:0]        mb_sum,
    output logic               px_stb,
    output logic [31:0]        p_x,
    output logic [31:0]        p_y,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic               wr_data,
    output logic               busy,
    output logic               frame_done
`ifdef SCAN_SCHED_WDOG_EN
    ,
    output logic               wdog_err
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         px_q, px_d;
    logic [31:0]         py_q, py_d;
    logic                lit_q, lit_d;
    logic                pend_q, pend_d;
    logic                done_q, done_d;
`ifdef SCAN_SCHED_WDOG_EN
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    logic last_col, last_row;
    assign last_col = (col_q == ADDR_W'(H_RES - 1));
    assign last_row = (row_q == ADDR_W'(V_RES - 1));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        px_d    = px_q;
        py_d    = py_q;
        lit_d   = lit_q;
        done_d  = 1'b0;
        // One-deep request queue; extra requests while busy are dropped.
        pend_d  = pend_q | (frame_start & (state_q != StIdle));
`ifdef SCAN_SCHED_WDOG_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (frame_start || pend_q) begin
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    px_d    = '0;
                    py_d    = '0;
                    pend_d  = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
`ifdef SCAN_SCHED_WDOG_EN
                cnt_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (&mb_vld) begin
                    lit_d   = (mb_sum >= THRESH);
                    state_d = StWrite;
                end
`ifdef SCAN_SCHED_WDOG_EN
                else if (cnt_q == 16'hFFFF) begin
                    lit_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            StWrite: begin
                // addr tracks row*H_RES+col without a multiplier.
                addr_d = addr_q + 1'b1;
                if (last_col && last_row) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (last_col) begin
                    col_d   = '0;
                    px_d    = '0;
                    row_d   = row_q + 1'b1;
                    py_d    = py_q + STEP;
                    state_d = StIssue;
                end else begin
                    col_d   = col_q + 1'b1;
                    px_d    = px_q + STEP;
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            lit_q   <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SCAN_SCHED_WDOG_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            px_q    <= px_d;
            py_q    <= py_d;
            lit_q   <= lit_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
`ifdef SCAN_SCHED_WDOG_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign px_stb     = (state_q == StIssue);
    assign wr_en      = (state_q == StWrite);
    assign busy       = (state_q != StIdle);
    assign wr_addr    = addr_q;
    assign wr_data    = lit_q;
    assign p_x        = px_q;
    assign p_y        = py_q;
    assign frame_done = done_q;
`ifdef SCAN_SCHED_WDOG_EN
    assign wdog_err   = err_q;
`endif

endmodule

// File: tb/tb_scan_sched.sv
// Directed bench for scan_sched on a 4x2 raster: table-driven frames plus stall, pending,
// mid-frame reset and (when SCAN_SCHED_WDOG_EN is defined) watchdog sequences.
module tb_scan_sched;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned NB = 2;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [NB-1:0] mb_vld = '0;
    logic [31:0]   mb_sum = '0;
    logic          px_stb, wr_en, wr_data, busy, frame_done;
    logic [31:0]   p_x, p_y;
    logic [AW-1:0] wr_addr;
`ifdef SCAN_SCHED_WDOG_EN
    logic          wdog_err;
`endif

    int total = 0;
    int bad   = 0;

    scan_sched #(
        .H_RES(H), .V_RES(V), .STEP(32'h0000_8000), .N_BALLS(NB),
        .THRESH(32'h0001_0000), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .mb_vld(mb_vld), .mb_sum(mb_sum),
        .px_stb(px_stb), .p_x(p_x), .p_y(p_y), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .frame_done(frame_done)
`ifdef SCAN_SCHED_WDOG_EN
        , .wdog_err(wdog_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        exp_d;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] px_tab [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first ISSUE cycle.
    task automatic kick();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] sum, input logic exp_d);
        int n = 0;
        int stb = 0;
        int done_cyc = -1;
        mb_sum = sum;
        mb_vld = 2'b11;
        kick();
        chk("first_stb", px_stb, 1);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (px_stb) stb++;
            if (wr_en) begin
                chk("wr_addr", wr_addr, n);
                chk("wr_data", wr_data, exp_d);
                chk("p_x", p_x, px_tab[n % 4]);
                chk("p_y", p_y, (n >= 4) ? 32'h0000_8000 : 32'h0);
                n++;
            end
            if (frame_done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("write_count", n, 8);
        chk("stb_count", stb, 8);
        chk("done_cycle", done_cyc, 24);
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_single", frame_done, 0);
    endtask

    initial begin
        int dn;
        int first_done;
        int second_done;
        int seen;

        vecs[0] = '{sum: 32'h0001_0000, exp_d: 1'b1};
        vecs[1] = '{sum: 32'h0000_FFFF, exp_d: 1'b0};
        vecs[2] = '{sum: 32'hFFFF_FFFF, exp_d: 1'b1};
        vecs[3] = '{sum: 32'h0000_0000, exp_d: 1'b0};
        px_tab[0] = 32'h0000_0000;
        px_tab[1] = 32'h0000_8000;
        px_tab[2] = 32'h0001_0000;
        px_tab[3] = 32'h0001_8000;

        @(negedge clk);
        chk("rst_outs", {px_stb, wr_en, wr_data, busy, frame_done}, 0);
        chk("rst_px", p_x, 0);
        chk("rst_py", p_y, 0);
        chk("rst_addr", wr_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i].sum, vecs[i].exp_d);

        // Partial valid holds the pixel in WAIT.
        mb_sum = 32'h0001_0000;
        mb_vld = 2'b01;
        kick();
        @(negedge clk);
        repeat (5) begin
            chk("stall_no_wr", wr_en, 0);
            chk("stall_no_stb", px_stb, 0);
            @(negedge clk);
        end
        mb_vld = 2'b11;
        @(negedge clk);
        chk("stall_wr", wr_en, 1);
        chk("stall_addr", wr_addr, 0);
        @(negedge clk);
        chk("stall_next_stb", px_stb, 1);
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            if (frame_done) seen = 1;
            else @(negedge clk);
        end
        chk("stall_done", seen, 1);
        @(negedge clk);

        // Requests mid-frame and on the final WRITE collapse into one extra frame.
        dn = 0;
        first_done = -1;
        second_done = -1;
        kick();
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (frame_done) begin
                dn++;
                if (dn == 1) first_done = cyc;
                else second_done = cyc;
            end
            if (first_done >= 0 && cyc == first_done + 1) begin
                chk("pend_stb", px_stb, 1);
                chk("pend_addr", wr_addr, 0);
            end
            frame_start = (cyc == 5) || (cyc == 10) || (dn == 0 && wr_en && wr_addr == 3'd7);
            @(negedge clk);
        end
        frame_start = 1'b0;
        chk("pend_frames", dn, 2);
        chk("pend_first", first_done, 24);
        chk("pend_second", second_done, 49);
        chk("pend_idle", busy, 0);

        // Asynchronous reset in the WAIT state of pixel 5.
        kick();
        repeat (16) @(negedge clk);
        chk("pre_rst_px", p_x, 32'h0000_8000);
        chk("pre_rst_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_outs", {px_stb, wr_en, wr_data, busy, frame_done}, 0);
        chk("arst_px", p_x, 0);
        chk("arst_py", p_y, 0);
        chk("arst_addr", wr_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (wr_en || frame_done || busy) seen++;
            @(negedge clk);
        end
        chk("arst_quiet", seen, 0);
        run_frame(32'h0001_0000, 1'b1);

`ifdef SCAN_SCHED_WDOG_EN
        mb_vld = 2'b00;
        kick();
        seen = 0;
        for (int c = 0; c < 70000 && seen == 0; c++) begin
            if (wr_en) seen = 1;
            else @(negedge clk);
        end
        chk("wdog_write", seen, 1);
        chk("wdog_data", wr_data, 0);
        chk("wdog_err", wdog_err, 1);
        repeat (5) @(negedge clk);
        chk("wdog_sticky", wdog_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wdog_clear", wdog_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
